dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single data-memory port between the pipeline MEM stage and a
// loader/debug requester. The pipeline has fixed priority; the loader uses idle
// MEM cycles. A starvation counter forces a pipeline freeze so the loader
// always completes. Sits between the EX/MEM register outputs and datamemory.
// PARAMETERS
// DM_ADDRESS  9   data memory byte-address width
// DATA_W      32  data width
// STARVE_LIM  8   consecutive denied loader cycles before freeze (>=1)
// CNT_W       16  width of loader transfer counter
// PORTS
// clk        in   1           clock, rising edge
// reset      in   1           asynchronous, active-high reset
// p_wr       in   1           pipeline write (C.MemWrite)
// p_rd       in   1           pipeline read (C.MemRead)
// p_addr     in   DM_ADDRESS  pipeline address
// p_wdata    in   DATA_W      pipeline write data
// p_func3    in   3           pipeline access size/sign
// p_rdata    out  DATA_W      read data to MEM/WB (= m_rdata)
// stall_req  out  1           freeze request to hazard logic (PC, IF/ID..EX/MEM held)
// l_req      in   1           loader request; held with l_we/l_addr/l_wdata/l_func3 until l_gnt
// l_we       in   1           loader write (1) / read (0)
// l_addr     in   DM_ADDRESS  loader address
// l_wdata    in   DATA_W      loader write data
// l_func3    in   3           loader access size/sign
// l_gnt      out  1           loader access performed this cycle
// l_rvalid   out  1           l_rdata valid (1-cycle pulse)
// l_rdata    out  DATA_W      registered loader read data
// l_xfer_cnt out  CNT_W       completed loader transfers, wraps
// m_wr,m_rd  out  1           memory write/read enables
// m_addr     out  DM_ADDRESS  memory address
// m_wdata    out  DATA_W      memory write data
// m_func3    out  3           memory access size
// m_rdata    in   DATA_W      memory read data, combinational from m_addr
// BEHAVIOUR
// - States: PIPE (normal), FORCE (pipeline frozen, loader owns port).
// - p_busy = p_wr|p_rd. l_gnt = l_req & (FORCE | ~p_busy), combinational.
// - Port mux: l_gnt -> loader fields, m_wr=l_we, m_rd=~l_we; else pipeline
//   fields. In FORCE with l_gnt=0, m_wr=m_rd=0 (pipeline access suppressed).
// - wait_cnt: +1 each cycle l_req & ~l_gnt, saturates at STARVE_LIM; cleared
//   on l_gnt or ~l_req.
// - PIPE->FORCE when l_req & ~l_gnt & wait_cnt==STARVE_LIM-1; stall_req is
//   registered, high from the first FORCE cycle.
// - FORCE->PIPE after any cycle in FORCE (grant done, or l_req dropped =
//   protocol violation, abandoned). FORCE lasts exactly one cycle.
// - Frozen pipeline replays its held access after stall_req falls; a write
//   replay is idempotent, so no data is lost or duplicated.
// - Read return: granted read -> l_rvalid=1, l_rdata=m_rdata on next edge;
//   l_rvalid low otherwise. Writes commit on the grant-cycle edge.
// - l_xfer_cnt +1 per l_gnt cycle, wraps 2^CNT_W-1 -> 0.
// - Reset (async): state=PIPE, wait_cnt=0, stall_req=0, l_rvalid=0,
//   l_rdata=0, l_xfer_cnt=0. Comb outputs follow inputs in reset; reset during
//   FORCE drops the freeze immediately, any in-flight loader read is lost.
// - Simultaneous: p_busy & l_req in PIPE -> pipeline wins; in FORCE -> loader.
// TESTING
// 1 Idle pipe, l_req read addr 0x010 holding 0xDEADBEEF -> l_gnt same cycle,
//   next cycle l_rvalid=1, l_rdata=0xDEADBEEF, l_xfer_cnt=1.
// 2 p_wr addr 0x020 data 0x11 with l_req write 0x22 same addr -> pipe writes,
//   l_gnt=0; next idle cycle loader writes; final mem[0x020]=0x22.
// 3 p_busy held continuously, l_req high, STARVE_LIM=8 -> stall_req high in
//   cycle 9, l_gnt=1 that cycle, stall_req low in cycle 10.
// 4 FORCE with pipe write pending addr 0x030 -> write suppressed during FORCE,
//   replayed next cycle; mem[0x030] equals pipe data, exactly one loader xfer.
// 5 Assert reset mid-FORCE -> stall_req, l_rvalid, l_xfer_cnt 0 immediately,
//   state PIPE; after release idle-cycle grant works as in test 1.
// 6 l_xfer_cnt at 0xFFFF (CNT_W=16) + one grant -> 0x0000.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (fixed priority)
// and a loader/debug requester, with a starvation-triggered one-cycle pipeline freeze.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_wr,
  input  logic                  p_rd,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  input  logic [2:0]            p_func3,
  output logic [DATA_W-1:0]     p_rdata,
  output logic                  stall_req,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [DM_ADDRESS-1:0] l_addr,
  input  logic [DATA_W-1:0]     l_wdata,
  input  logic [2:0]            l_func3,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_W-1:0]     l_rdata,
  output logic [CNT_W-1:0]      l_xfer_cnt,
  output logic                  m_wr,
  output logic                  m_rd,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [2:0]            m_func3,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int WAIT_W = $clog2(STARVE_LIM + 1);

  localparam logic [0:0] S_PIPE  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;

  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIM);
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(STARVE_LIM - 1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;

  logic p_busy;
  logic in_force;
  logic gnt;

  assign p_busy   = p_wr | p_rd;
  assign in_force = (state_q == S_FORCE);
  assign gnt      = l_req & (in_force | ~p_busy);

  // In FORCE without a grant the frozen pipeline access must not reach memory.
  always_comb begin
    m_addr  = p_addr;
    m_wdata = p_wdata;
    m_func3 = p_func3;
    m_wr    = p_wr;
    m_rd    = p_rd;
    if (gnt) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_func3 = l_func3;
      m_wr    = l_we;
      m_rd    = ~l_we;
    end else if (in_force) begin
      m_wr = 1'b0;
      m_rd = 1'b0;
    end
  end

  always_comb begin
    state_d  = S_PIPE;
    wait_d   = '0;
    rvalid_d = gnt & ~l_we;
    rdata_d  = rdata_q;
    xfer_d   = xfer_q;

    if (l_req && !gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end

    // A freeze always lasts a single cycle, whether or not the loader stayed.
    if (!in_force && l_req && !gnt && (wait_q == WAIT_TRIP)) begin
      state_d = S_FORCE;
    end

    if (gnt) begin
      xfer_d = xfer_q + CNT_W'(1);
      if (!l_we) begin
        rdata_d = m_rdata;
      end
    end

    stall_d = (state_d == S_FORCE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_PIPE;
      wait_q   <= '0;
      stall_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      xfer_q   <= xfer_d;
    end
  end

  assign l_gnt      = gnt;
  assign stall_req  = stall_q;
  assign l_rvalid   = rvalid_q;
  assign l_rdata    = rdata_q;
  assign l_xfer_cnt = xfer_q;
  assign p_rdata    = m_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised and directed checks of dmem_port_arbiter against a transaction-level
// model of port ownership, starvation freezes, loader read returns and transfer counting.
module tb_dmem_port_arbiter;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int STARVE_LIM = 8;
  localparam int CNT_W      = 16;
  localparam int DEPTH      = 1 << DM_ADDRESS;
  localparam int CNT_MOD    = 1 << CNT_W;

  logic                  clk;
  logic                  reset;
  logic                  p_wr, p_rd;
  logic [DM_ADDRESS-1:0] p_addr;
  logic [DATA_W-1:0]     p_wdata;
  logic [2:0]            p_func3;
  logic [DATA_W-1:0]     p_rdata;
  logic                  stall_req;
  logic                  l_req, l_we;
  logic [DM_ADDRESS-1:0] l_addr;
  logic [DATA_W-1:0]     l_wdata;
  logic [2:0]            l_func3;
  logic                  l_gnt, l_rvalid;
  logic [DATA_W-1:0]     l_rdata;
  logic [CNT_W-1:0]      l_xfer_cnt;
  logic                  m_wr, m_rd;
  logic [DM_ADDRESS-1:0] m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [2:0]            m_func3;
  logic [DATA_W-1:0]     m_rdata;

  int testsRun    = 0;
  int testsFailed = 0;
  logic started   = 1'b0;

  dmem_port_arbiter #(
    .DM_ADDRESS(DM_ADDRESS),
    .DATA_W    (DATA_W),
    .STARVE_LIM(STARVE_LIM),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p_wr      (p_wr),
    .p_rd      (p_rd),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_func3   (p_func3),
    .p_rdata   (p_rdata),
    .stall_req (stall_req),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_func3   (l_func3),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .l_xfer_cnt(l_xfer_cnt),
    .m_wr      (m_wr),
    .m_rd      (m_rd),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_func3   (m_func3),
    .m_rdata   (m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical memory driven by the DUT's port.
  logic [DATA_W-1:0] mem [DEPTH];
  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (!reset && m_wr) mem[m_addr] <= m_wdata;
  end

  // Reference model: who owns the port, how many denials in a row, what the loader sees.
  logic [DATA_W-1:0] refMem [DEPTH];
  logic              mdlFrozen;
  int                mdlDenied;
  logic              mdlRvalid;
  logic [DATA_W-1:0] mdlRdata;
  int                mdlCnt;
  logic              mdlGntPrev;

  always @(posedge clk or posedge reset) begin
    logic g;
    if (reset) begin
      mdlFrozen  <= 1'b0;
      mdlDenied  <= 0;
      mdlRvalid  <= 1'b0;
      mdlRdata   <= '0;
      mdlCnt     <= 0;
      mdlGntPrev <= 1'b0;
    end else begin
      g = l_req && (mdlFrozen || !(p_wr || p_rd));
      mdlGntPrev <= g;
      if (g) begin
        mdlCnt    <= (mdlCnt + 1) % CNT_MOD;
        mdlRvalid <= !l_we;
        if (!l_we) mdlRdata <= refMem[l_addr];
        else       refMem[l_addr] <= l_wdata;
      end else begin
        mdlRvalid <= 1'b0;
        if (!mdlFrozen && p_wr) refMem[p_addr] <= p_wdata;
      end
      if (mdlFrozen) begin
        mdlFrozen <= 1'b0;
        mdlDenied <= 0;
      end else if (l_req && !g) begin
        if (mdlDenied + 1 >= STARVE_LIM) mdlFrozen <= 1'b1;
        mdlDenied <= mdlDenied + 1;
      end else begin
        mdlDenied <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, mid-period, the DUT must agree with the model.
  always @(negedge clk) begin
    logic                  g, eWr, eRd;
    logic [DM_ADDRESS-1:0] eAddr;
    logic [DATA_W-1:0]     eData;
    logic [2:0]            eF3;
    if (started) begin
      g     = l_req && (mdlFrozen || !(p_wr || p_rd));
      eWr   = p_wr;
      eRd   = p_rd;
      eAddr = p_addr;
      eData = p_wdata;
      eF3   = p_func3;
      if (g) begin
        eWr = l_we; eRd = !l_we; eAddr = l_addr; eData = l_wdata; eF3 = l_func3;
      end else if (mdlFrozen) begin
        eWr = 1'b0; eRd = 1'b0;
      end
      checkOutput("l_gnt", 64'(l_gnt), 64'(g));
      checkOutput("m_wr", 64'(m_wr), 64'(eWr));
      checkOutput("m_rd", 64'(m_rd), 64'(eRd));
      if (eWr || eRd) begin
        checkOutput("m_addr", 64'(m_addr), 64'(eAddr));
        checkOutput("m_func3", 64'(m_func3), 64'(eF3));
      end
      if (eWr) checkOutput("m_wdata", 64'(m_wdata), 64'(eData));
      if (eRd) checkOutput("p_rdata", 64'(p_rdata), 64'(refMem[eAddr]));
      checkOutput("stall_req", 64'(stall_req), 64'(mdlFrozen));
      checkOutput("l_rvalid", 64'(l_rvalid), 64'(mdlRvalid));
      if (mdlRvalid) checkOutput("l_rdata", 64'(l_rdata), 64'(mdlRdata));
      checkOutput("l_xfer_cnt", 64'(l_xfer_cnt), 64'(mdlCnt));
    end
  end

  task automatic applyStimulus(input logic pw, input logic pr, input logic [DM_ADDRESS-1:0] pa,
                               input logic [DATA_W-1:0] pd, input logic [2:0] pf,
                               input logic lr, input logic lw, input logic [DM_ADDRESS-1:0] la,
                               input logic [DATA_W-1:0] ld, input logic [2:0] lf);
    p_wr = pw; p_rd = pr; p_addr = pa; p_wdata = pd; p_func3 = pf;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_func3 = lf;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, '0, '0, 3'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt0;
    int guard;
    logic heavy;
    logic wasFrozen;

    reset = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
      refMem[i] = 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
    end
    mem[9'h010]    = 32'hDEADBEEF;
    refMem[9'h010] = 32'hDEADBEEF;

    #1 reset = 1'b1;
    started = 1'b1;
    #1;
    checkOutput("rst_stall", 64'(stall_req), 64'd0);
    checkOutput("rst_rvalid", 64'(l_rvalid), 64'd0);
    checkOutput("rst_rdata", 64'(l_rdata), 64'd0);
    checkOutput("rst_cnt", 64'(l_xfer_cnt), 64'd0);
    nextCycle();
    nextCycle();
    reset = 1'b0;

    // Idle pipeline: loader read granted at once, data back next cycle.
    applyStimulus(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b0, 9'h010, '0, 3'd2);
    @(negedge clk);
    checkOutput("t1_gnt", 64'(l_gnt), 64'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t1_rvalid", 64'(l_rvalid), 64'd1);
    checkOutput("t1_rdata", 64'(l_rdata), 64'hDEADBEEF);
    checkOutput("t1_cnt", 64'(l_xfer_cnt), 64'd1);
    nextCycle();

    // Same-address collision: pipeline first, loader on the next idle cycle.
    applyStimulus(1'b1, 1'b0, 9'h020, 32'h11, 3'd2, 1'b1, 1'b1, 9'h020, 32'h22, 3'd2);
    @(negedge clk);
    checkOutput("t2_gnt_denied", 64'(l_gnt), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 9'h020, 32'h22, 3'd2);
    @(negedge clk);
    checkOutput("t2_gnt", 64'(l_gnt), 64'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t2_mem", 64'(mem[9'h020]), 64'h22);
    nextCycle();

    // Continuous pipeline traffic: freeze in cycle 9 only.
    applyStimulus(1'b0, 1'b1, 9'h060, '0, 3'd2, 1'b1, 1'b0, 9'h070, '0, 3'd2);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_stall_c%0d", c), 64'(stall_req), 64'(c == 9));
      checkOutput($sformatf("t3_gnt_c%0d", c), 64'(l_gnt), 64'(c == 9));
      nextCycle();
      if (c == 9) applyStimulus(1'b0, 1'b1, 9'h060, '0, 3'd2, 1'b0, 1'b0, '0, '0, 3'd0);
    end
    idle();
    nextCycle();

    // Pending pipeline write suppressed during the freeze and replayed afterwards.
    cnt0 = int'(l_xfer_cnt);
    applyStimulus(1'b1, 1'b0, 9'h030, 32'h3030_3030, 3'd2, 1'b1, 1'b1, 9'h050, 32'hA5A5_0050, 3'd2);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 9) begin
        checkOutput("t4_stall", 64'(stall_req), 64'd1);
        checkOutput("t4_gnt", 64'(l_gnt), 64'd1);
        checkOutput("t4_addr", 64'(m_addr), 64'h050);
      end
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 9'h030, 32'h3030_3030, 3'd2, 1'b0, 1'b0, '0, '0, 3'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t4_mem_pipe", 64'(mem[9'h030]), 64'h3030_3030);
    checkOutput("t4_mem_ldr", 64'(mem[9'h050]), 64'hA5A5_0050);
    checkOutput("t4_one_xfer", 64'(l_xfer_cnt), 64'((cnt0 + 1) % CNT_MOD));
    nextCycle();

    // Random traffic with bursty pipeline load and protocol-respecting loader.
    heavy = 1'b0;
    wasFrozen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 19) == 0) heavy = ~heavy;
      if (!(mdlFrozen || wasFrozen)) begin
        r = int'($urandom_range(0, 99));
        p_wr    = heavy ? (r < 50) : (r < 15);
        p_rd    = heavy ? (r >= 50 && r < 97) : (r >= 15 && r < 30);
        p_addr  = 9'($urandom_range(0, 15));
        p_wdata = $urandom;
        p_func3 = 3'($urandom_range(0, 7));
      end
      wasFrozen = mdlFrozen;
      if (l_req && !mdlGntPrev && $urandom_range(0, 49) != 0) begin
        l_req = 1'b1;
      end else begin
        l_req   = ($urandom_range(0, 2) != 0);
        l_we    = $urandom_range(0, 1) == 1;
        l_addr  = 9'($urandom_range(0, 15));
        l_wdata = $urandom;
        l_func3 = 3'($urandom_range(0, 7));
      end
      nextCycle();
    end
    idle();
    nextCycle();

    // Drive the transfer counter to its top value, then wrap it.
    applyStimulus(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 9'h1F0, 32'h0000_F0F0, 3'd2);
    guard = 0;
    while (mdlCnt != CNT_MOD - 1 && guard < 70000) begin
      nextCycle();
      guard++;
    end
    if (guard >= 70000) checkOutput("t6_reach_top", 64'd0, 64'd1);
    @(negedge clk);
    checkOutput("t6_top", 64'(l_xfer_cnt), 64'hFFFF);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t6_wrap", 64'(l_xfer_cnt), 64'h0000);
    nextCycle();

    // Reset asserted in the middle of a freeze.
    applyStimulus(1'b0, 1'b1, 9'h060, '0, 3'd2, 1'b1, 1'b0, 9'h070, '0, 3'd2);
    for (int c = 1; c <= 8; c++) nextCycle();
    #1;
    checkOutput("t5_in_force", 64'(stall_req), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_stall", 64'(stall_req), 64'd0);
    checkOutput("t5_rvalid", 64'(l_rvalid), 64'd0);
    checkOutput("t5_cnt", 64'(l_xfer_cnt), 64'd0);
    checkOutput("t5_gnt_pipe", 64'(l_gnt), 64'd0);
    idle();
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 3'd0, 1'b1, 1'b0, 9'h010, '0, 3'd2);
    @(negedge clk);
    checkOutput("t5_gnt", 64'(l_gnt), 64'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t5_rvalid_after", 64'(l_rvalid), 64'd1);
    checkOutput("t5_rdata_after", 64'(l_rdata), 64'hDEADBEEF);
    checkOutput("t5_cnt_after", 64'(l_xfer_cnt), 64'd1);
    nextCycle();

    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
